// File: rtl/gate_check_pkg.sv
// Package gate_check_pkg
// Shared types and constants for the gate_vector_checker.
//   state_e  : FSM states of the checker
//   EXP      : expected 7-bit gate results indexed by {a,b}
//   gate_ref : behavioural gate block, returns the 7-bit result vector
// Result bit order: [6]and [5]or [4]nand [3]nor [2]xor [1]xnor [0]not(a)
package gate_check_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [6:0] EXP [4] = '{7'h1B, 7'h35, 7'h34, 7'h62};

    function automatic logic [6:0] gate_ref(input logic a, input logic b);
        return {a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b), ~a};
    endfunction

endpackage

// File: rtl/gate_vector_checker.sv
// Module gate_vector_checker
// Stimulus/response engine for a 2-input, 7-output gate block. On start it
// sweeps {a,b} through 00,01,10,11 NUM_PASSES times, waits SETTLE_CYCLES after
// each drive, compares res_in with the expected truth table and counts
// mismatching vectors (saturating). done pulses for one cycle at the end and
// pass reports whether the run was clean.
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   start          in   begin a run (honoured only in IDLE or DONE)
//   busy           out  run in progress
//   done           out  one-cycle completion pulse
//   pass           out  last run had zero mismatches
//   a_out, b_out   out  stimulus to the gate block
//   res_in         in   gate results [6]and [5]or [4]nand [3]nor [2]xor [1]xnor [0]not(a)
//   err_count      out  mismatching vectors this run, saturates at all-ones
//   first_err_vec  out  {a,b} of the first failing vector
//   first_err_mask out  res_in ^ expected at the first failure
// Configuration macro GATE_CHECK_FIRST_ERR_EN: when defined, first_err_vec and
// first_err_mask capture the first mismatch of each run; when undefined they
// are tied to zero and no capture registers exist.
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             a_out,
    output logic             b_out,
    input  logic [6:0]       res_in,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_err_vec,
    output logic [6:0]       first_err_mask
);

    localparam int SET_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam int PASS_W = (NUM_PASSES < 2) ? 1 : $clog2(NUM_PASSES);

    state_e             state_q, state_d;
    logic [1:0]         v_q, v_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [PASS_W-1:0]  pcnt_q, pcnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               pass_q, pass_d;
    logic               a_q, a_d;
    logic               b_q, b_d;

    logic start_acc;
    logic mism;

    assign start_acc = start && (state_q == IDLE || state_q == DONE);
    assign mism      = (res_in != EXP[v_q]);

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        set_d   = set_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    err_d   = '0;
                    pass_d  = 1'b0;
                    v_d     = 2'd0;
                    pcnt_d  = '0;
                    state_d = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                {a_d, b_d} = v_q;
                set_d      = '0;
                state_d    = SETTLE;
            end
            SETTLE: begin
                if (set_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = CHECK;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            CHECK: begin
                if (mism && (err_q != {ERR_W{1'b1}})) begin
                    err_d = err_q + ERR_W'(1);
                end
                v_d     = v_q + 2'd1;
                state_d = DRIVE;
                // A sweep ends when vector 3 has been checked.
                if (v_q == 2'd3) begin
                    if (pcnt_q == PASS_W'(NUM_PASSES - 1)) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        pcnt_d = pcnt_q + PASS_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= 2'd0;
            set_q   <= '0;
            pcnt_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            set_q   <= set_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign busy      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign err_count = err_q;

`ifdef GATE_CHECK_FIRST_ERR_EN
    logic [1:0] fvec_q, fvec_d;
    logic [6:0] fmask_q, fmask_d;

    // err_q still zero in CHECK means no earlier vector of this run failed.
    always_comb begin
        fvec_d  = fvec_q;
        fmask_d = fmask_q;
        if (start_acc) begin
            fvec_d  = 2'd0;
            fmask_d = 7'd0;
        end else if (state_q == CHECK && mism && err_q == '0) begin
            fvec_d  = v_q;
            fmask_d = res_in ^ EXP[v_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fvec_q  <= 2'd0;
            fmask_q <= 7'd0;
        end else begin
            fvec_q  <= fvec_d;
            fmask_q <= fmask_d;
        end
    end

    assign first_err_vec  = fvec_q;
    assign first_err_mask = fmask_q;
`else
    assign first_err_vec  = 2'd0;
    assign first_err_mask = 7'd0;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic       busy1, done1, pass1, a1, b1;
    logic       busy2, done2, pass2, a2, b2;
    logic [6:0] res1, res2;
    logic [7:0] err1;
    logic [1:0] err2;
    logic [1:0] fv1, fv2;
    logic [6:0] fm1, fm2;

    logic [6:0] xm [4];
    logic [6:0] am;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Truth table from the gate definitions, using integer arithmetic.
    function automatic logic [6:0] tb_gate(input logic [1:0] v);
        int a, b;
        logic [6:0] r;
        a = int'(v[1]);
        b = int'(v[0]);
        r[6] = (a * b) == 1;
        r[5] = (a + b) > 0;
        r[4] = (a * b) == 0;
        r[3] = (a + b) == 0;
        r[2] = (a + b) == 1;
        r[1] = (a + b) != 1;
        r[0] = a == 0;
        return r;
    endfunction

    // Loopback with optional per-vector fault injection.
    always_comb begin
        res1 = (tb_gate({a1, b1}) ^ xm[{a1, b1}]) & am;
        res2 = ~tb_gate({a2, b2});
    end

    gate_vector_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .ERR_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .a_out(a1), .b_out(b1), .res_in(res1), .err_count(err1),
        .first_err_vec(fv1), .first_err_mask(fm1)
    );

    gate_vector_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .pass(pass2), .a_out(a2), .b_out(b2), .res_in(res2), .err_count(err2),
        .first_err_vec(fv2), .first_err_mask(fm2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference outcome of one run of dut1 from the current fault setup.
    task automatic model(input int npass, input int errmax, output int e, output logic p,
                         output logic [1:0] fv, output logic [6:0] fm);
        logic [6:0] good, got;
        e = 0; fv = 2'd0; fm = 7'd0;
        for (int n = 0; n < npass; n++) begin
            for (int v = 0; v < 4; v++) begin
                good = tb_gate(2'(v));
                got  = (good ^ xm[v]) & am;
                if (got != good) begin
                    if (e == 0) begin
                        fv = 2'(v);
                        fm = got ^ good;
                    end
                    if (e < errmax) e++;
                end
            end
        end
        p = (e == 0);
`ifndef GATE_CHECK_FIRST_ERR_EN
        fv = 2'd0;
        fm = 7'd0;
`endif
    endtask

    // Waits for done after the start edge; lat counts cycles since that edge.
    task automatic wait_done1(input bit mid, output int lat);
        lat = 1;
        while (done1 !== 1'b1 && lat < 300) begin
            start1 = (mid && lat == 5);
            tick();
            lat++;
        end
        start1 = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input bit mid);
        int lat, e;
        logic p;
        logic [1:0] fv;
        logic [6:0] fm;
        model(1, 255, e, p, fv, fm);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk({tag, "_busy"}, 32'(busy1), 32'd1);
        wait_done1(mid, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd17);
        chk({tag, "_done_busy"}, 32'(busy1), 32'd0);
        chk({tag, "_err"}, 32'(err1), 32'(e));
        chk({tag, "_pass"}, 32'(pass1), 32'(p));
        chk({tag, "_fvec"}, 32'(fv1), 32'(fv));
        chk({tag, "_fmask"}, 32'(fm1), 32'(fm));
    endtask

    initial begin
        int lat, e, drops;
        logic p;
        logic [1:0] fv;
        logic [6:0] fm;

        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        for (int v = 0; v < 4; v++) xm[v] = 7'd0;
        am = 7'h7F;
        tick(); tick(); tick();
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_pass", 32'(pass1), 32'd0);
        chk("rst_ab", 32'({a1, b1}), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_fvec", 32'(fv1), 32'd0);
        chk("rst_fmask", 32'(fm1), 32'd0);
        chk("rst_err2", 32'(err2), 32'd0);
        rst = 1'b0;
        tick();

        // Ideal loopback.
        run_and_check("ideal", 1'b0);
        tick();
        chk("ideal_done_clr", 32'(done1), 32'd0);
        chk("ideal_pass_hold", 32'(pass1), 32'd1);
        chk("ideal_ab_hold", 32'({a1, b1}), 32'd3);

        // xor output stuck at 0.
        am = 7'h7B;
        run_and_check("stuck_xor", 1'b0);
        tick();
        am = 7'h7F;

        // Randomised fault patterns.
        for (int it = 0; it < 6; it++) begin
            for (int v = 0; v < 4; v++)
                xm[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
            run_and_check("rand", 1'b0);
            tick();
        end

        // Start pulsed mid-run is ignored.
        for (int v = 0; v < 4; v++) xm[v] = 7'd0;
        xm[2] = 7'h11;
        run_and_check("mid_start", 1'b1);

        // Restart in the done cycle: first a clean run, then a faulty one.
        for (int v = 0; v < 4; v++) xm[v] = 7'd0;
        tick();
        run_and_check("pre_restart", 1'b0);
        xm[3] = 7'h40;
        model(1, 255, e, p, fv, fm);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("restart_busy", 32'(busy1), 32'd1);
        chk("restart_pass_clr", 32'(pass1), 32'd0);
        chk("restart_err_clr", 32'(err1), 32'd0);
        wait_done1(1'b0, lat);
        chk("restart_lat", 32'(lat), 32'd17);
        chk("restart_err", 32'(err1), 32'(e));
        chk("restart_pass", 32'(pass1), 32'(p));
        tick();

        // Reset mid-run at cycle 8.
        for (int v = 0; v < 4; v++) xm[v] = 7'd0;
        xm[0] = 7'h01;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        chk("pre_rst_ab", 32'({a1, b1}), 32'd1);
        chk("pre_rst_err", 32'(err1), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_ab", 32'({a1, b1}), 32'd0);
        chk("midrst_err", 32'(err1), 32'd0);
        chk("midrst_done", 32'(done1), 32'd0);
        drops = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (done1 === 1'b1) drops++;
        end
        chk("midrst_no_done", 32'(drops), 32'd0);

        // Four passes, 2-bit counter, every output inverted.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 1;
        while (done2 !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        chk("sat_lat", 32'(lat), 32'd65);
        chk("sat_err", 32'(err2), 32'd3);
        chk("sat_pass", 32'(pass2), 32'd0);
`ifdef GATE_CHECK_FIRST_ERR_EN
        chk("sat_fvec", 32'(fv2), 32'd0);
        chk("sat_fmask", 32'(fm2), 32'h7F);
`else
        chk("sat_fvec", 32'(fv2), 32'd0);
        chk("sat_fmask", 32'(fm2), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
